alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one ALU datapath, and the 5-bit ALU control code that drives it, between two requesters.
- Requester 0 is the execute-stage issue path; requester 1 is the debug/CSR side path.
- Each request carries a control code, for example ADD=5'b00011, SUB=5'b00100 or BEQ=5'b01010, plus two operands.
- The block arbitrates round-robin, sequences the ALU for a configurable latency, captures the result and returns it with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32: operand and result width.
- ALU_LAT, 1: cycles the ALU result takes after operands are applied. Legal range is 1..15.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous and active-low
- i_req0_valid  in  1  requester 0 has an operation
- i_req0_ctrl  in  5  requester 0 ALU control code
- i_req0_a  in  DATA_WIDTH  requester 0 operand A
- i_req0_b  in  DATA_WIDTH  requester 0 operand B
- o_req0_ready  out  1  requester 0 request accepted this cycle
- i_req1_valid, i_req1_ctrl, i_req1_a, i_req1_b, o_req1_ready: same as above, for requester 1
- o_alu_valid  out  1  operands on the ALU bus are live
- o_alu_ctrl  out  5  control code to the ALU
- o_alu_a  out  DATA_WIDTH  operand A to the ALU
- o_alu_b  out  DATA_WIDTH  operand B to the ALU
- i_alu_result  in  DATA_WIDTH  ALU result
- o_rsp_valid  out  1  response available
- o_rsp_id  out  1  requester owning the response
- o_rsp_data  out  DATA_WIDTH  captured result
- o_rsp_illegal  out  1  control code was above 5'b01111
- i_rsp0_ready  in  1  requester 0 accepts the response
- i_rsp1_ready  in  1  requester 1 accepts the response

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE; last_grant=1, so requester 0 wins first.
  - o_alu_valid=0, o_rsp_valid=0, o_rsp_illegal=0.
  - o_alu_ctrl, o_alu_a, o_alu_b, o_rsp_data, o_rsp_id = 0.
  - Reset mid-operation discards the in-flight op. No response is produced for it.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - o_reqN_ready = grantN, combinational. Ready is never asserted outside IDLE.
  - Grant rules:
    - Only one valid: that requester is granted.
    - Both valid: the requester that is not last_grant is granted.
  - On handshake (valid & ready), at the next edge:
    - Register ctrl, a and b.
    - Set rsp_id = grant and last_grant = grant.
    - Load cnt = ALU_LAT-1 and enter EXEC.
  - Neither valid: stay in IDLE.
- EXEC:
  - o_alu_valid=1; o_alu_ctrl, o_alu_a and o_alu_b come from registers and are stable for the whole state.
  - cnt decrements each cycle.
  - When cnt==0:
    - Capture i_alu_result into o_rsp_data.
    - Set o_rsp_illegal = (ctrl > 5'b01111).
    - Enter RESP.
  - On exit, o_alu_valid drops. The operand registers hold their value.
- RESP:
  - o_rsp_valid=1. o_rsp_id, o_rsp_data and o_rsp_illegal are held stable.
  - Leave to IDLE on i_rsp{o_rsp_id}_ready. The other requester's ready is ignored.
  - No timeout: a response may be held indefinitely.
- Latency and throughput:
  - Accept to o_rsp_valid = ALU_LAT+1 cycles.
  - Back-to-back issue rate is one op per ALU_LAT+2 cycles, with same-cycle response acceptance.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1.
- Requester obligations:
  - A requester must hold valid and its payload until ready.
  - Deasserting valid before ready withdraws the request. It is not an error.
- Illegal control codes (16..31) are still forwarded to the ALU; the result is returned with o_rsp_illegal=1.
- Branch codes (5'b01010..5'b01111): the result is passed through unchanged, and the requester interprets bit 0.
- Counter width: 4 bits. ALU_LAT outside 1..15 is a compile-time error via an elaboration check.

Decomposition:
- Shared package osiris_i_pkg holds:
  - The ALU control localparams: AND..BGEU, 5'b00000..5'b01111.
  - ALU_CTRL_MAX = 5'b01111.
  - The state enum {IDLE, EXEC, RESP}.
- One sub-module, rr_arbiter_2: the two-input round-robin grant from the valids and last_grant. It is purely combinational.
- The FSM, counter and registers stay in alu_share_arbiter.

Test Plan:
- Single request, ALU_LAT=1: req0 ADD (5'b00011), a=5, b=7; ALU model returns 12.
  - o_req0_ready is high in the request cycle.
  - o_alu_valid is high 1 cycle later.
  - o_rsp_valid=1, id=0, data=12 two cycles after accept.
- Contention: both valid every cycle for 6 ops.
  - Grants are 0,1,0,1,0,1.
  - The losing requester's ready stays 0 until its turn.
- Latency: ALU_LAT=4, req1 SUB (5'b00100), a=10, b=3.
  - o_alu_valid is high exactly 4 cycles with stable operands.
  - Response data=7, id=1.
- Backpressure: hold i_rsp0_ready=0 for 10 cycles during RESP.
  - o_rsp_valid and o_rsp_data stay stable.
  - No new ready is issued even with req1 valid.
  - The response completes on the ready=1 cycle, then req1 is granted.
- Illegal code and reset:
  - req0 ctrl=5'b10101 -> o_rsp_illegal=1.
  - Assert i_rst_n=0 asynchronously mid-EXEC -> all outputs 0 immediately; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/osiris_i_pkg.sv
// Shared definitions for the ALU sharing arbiter.
// Holds the 5-bit ALU control codes, the highest legal code, the arbiter
// FSM state type, the sequencing counter width and a small helper that
// classifies a control code as illegal.
package osiris_i_pkg;

    localparam logic [4:0] AND  = 5'b00000;
    localparam logic [4:0] OR   = 5'b00001;
    localparam logic [4:0] XOR  = 5'b00010;
    localparam logic [4:0] ADD  = 5'b00011;
    localparam logic [4:0] SUB  = 5'b00100;
    localparam logic [4:0] SLL  = 5'b00101;
    localparam logic [4:0] SRL  = 5'b00110;
    localparam logic [4:0] SRA  = 5'b00111;
    localparam logic [4:0] SLT  = 5'b01000;
    localparam logic [4:0] SLTU = 5'b01001;
    localparam logic [4:0] BEQ  = 5'b01010;
    localparam logic [4:0] BNE  = 5'b01011;
    localparam logic [4:0] BLT  = 5'b01100;
    localparam logic [4:0] BGE  = 5'b01101;
    localparam logic [4:0] BLTU = 5'b01110;
    localparam logic [4:0] BGEU = 5'b01111;

    localparam logic [4:0] ALU_CTRL_MAX = 5'b01111;

    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Codes 16..31 are not defined for the ALU; they still run but get flagged.
    function automatic logic ctrl_illegal(input logic [4:0] ctrl);
        return (ctrl > ALU_CTRL_MAX);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bus bundle for alu_share_arbiter.
// Carries both requester channels, the shared ALU operand/result bus and
// the response channel.
//   slave  : the arbiter side (drives readies, ALU bus and response)
//   master : the environment side (requesters, ALU, response consumers)
interface alu_share_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_req0_valid;
    logic [4:0]            i_req0_ctrl;
    logic [DATA_WIDTH-1:0] i_req0_a;
    logic [DATA_WIDTH-1:0] i_req0_b;
    logic                  o_req0_ready;

    logic                  i_req1_valid;
    logic [4:0]            i_req1_ctrl;
    logic [DATA_WIDTH-1:0] i_req1_a;
    logic [DATA_WIDTH-1:0] i_req1_b;
    logic                  o_req1_ready;

    logic                  o_alu_valid;
    logic [4:0]            o_alu_ctrl;
    logic [DATA_WIDTH-1:0] o_alu_a;
    logic [DATA_WIDTH-1:0] o_alu_b;
    logic [DATA_WIDTH-1:0] i_alu_result;

    logic                  o_rsp_valid;
    logic                  o_rsp_id;
    logic [DATA_WIDTH-1:0] o_rsp_data;
    logic                  o_rsp_illegal;
    logic                  i_rsp0_ready;
    logic                  i_rsp1_ready;

    modport slave (
        input  i_req0_valid, i_req0_ctrl, i_req0_a, i_req0_b,
        input  i_req1_valid, i_req1_ctrl, i_req1_a, i_req1_b,
        input  i_alu_result, i_rsp0_ready, i_rsp1_ready,
        output o_req0_ready, o_req1_ready,
        output o_alu_valid, o_alu_ctrl, o_alu_a, o_alu_b,
        output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_illegal
    );

    modport master (
        output i_req0_valid, i_req0_ctrl, i_req0_a, i_req0_b,
        output i_req1_valid, i_req1_ctrl, i_req1_a, i_req1_b,
        output i_alu_result, i_rsp0_ready, i_rsp1_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_alu_valid, o_alu_ctrl, o_alu_a, o_alu_b,
        input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_illegal
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin grant, purely combinational.
// Ports:
//   valid0, valid1 : request valids
//   last_grant     : requester granted most recently
//   grant_valid    : some requester is granted
//   grant          : index of the granted requester
module rr_arbiter_2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    // Single requester wins outright; on contention the one not served last wins.
    always_comb begin
        grant_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the execute-stage issue path (requester 0) and the
// debug/CSR side path (requester 1). Grants round-robin, holds operands on
// the ALU bus for ALU_LAT cycles, captures the result and returns it on a
// valid/ready response channel tagged with the owning requester.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : requester, ALU and response signals (slave side)
module alu_share_arbiter
    import osiris_i_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ALU_LAT    = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    alu_share_arbiter_if.slave  bus
);

    if ((ALU_LAT < 1) || (ALU_LAT > 15)) begin : g_bad_alu_lat
        $error("alu_share_arbiter: ALU_LAT must be within 1..15");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(ALU_LAT - 1);

    state_e                state_r;
    logic                  last_grant_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [4:0]            ctrl_r;
    logic [DATA_WIDTH-1:0] a_r;
    logic [DATA_WIDTH-1:0] b_r;
    logic                  alu_valid_r;
    logic                  rsp_valid_r;
    logic                  rsp_id_r;
    logic [DATA_WIDTH-1:0] rsp_data_r;
    logic                  rsp_illegal_r;

    logic                  grant_valid_s;
    logic                  grant_s;
    logic                  rsp_ready_s;

    rr_arbiter_2 u_rr (
        .valid0      (bus.i_req0_valid),
        .valid1      (bus.i_req1_valid),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant       (grant_s)
    );

    // Only the owner's response ready may retire the response.
    always_comb begin
        if (rsp_id_r) begin
            rsp_ready_s = bus.i_rsp1_ready;
        end else begin
            rsp_ready_s = bus.i_rsp0_ready;
        end
    end

    // Readies are the grant itself, gated so they only appear while idle.
    assign bus.o_req0_ready = (state_r == IDLE) & grant_valid_s & ~grant_s;
    assign bus.o_req1_ready = (state_r == IDLE) & grant_valid_s &  grant_s;

    assign bus.o_alu_valid   = alu_valid_r;
    assign bus.o_alu_ctrl    = ctrl_r;
    assign bus.o_alu_a       = a_r;
    assign bus.o_alu_b       = b_r;
    assign bus.o_rsp_valid   = rsp_valid_r;
    assign bus.o_rsp_id      = rsp_id_r;
    assign bus.o_rsp_data    = rsp_data_r;
    assign bus.o_rsp_illegal = rsp_illegal_r;

    // Arbitration/sequencing FSM with all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= IDLE;
            last_grant_r  <= 1'b1;
            cnt_r         <= {CNT_WIDTH{1'b0}};
            ctrl_r        <= 5'b00000;
            a_r           <= {DATA_WIDTH{1'b0}};
            b_r           <= {DATA_WIDTH{1'b0}};
            alu_valid_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_id_r      <= 1'b0;
            rsp_data_r    <= {DATA_WIDTH{1'b0}};
            rsp_illegal_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // A grant is always a handshake, since ready mirrors the grant.
                    if (grant_valid_s) begin
                        if (grant_s) begin
                            ctrl_r <= bus.i_req1_ctrl;
                            a_r    <= bus.i_req1_a;
                            b_r    <= bus.i_req1_b;
                        end else begin
                            ctrl_r <= bus.i_req0_ctrl;
                            a_r    <= bus.i_req0_a;
                            b_r    <= bus.i_req0_b;
                        end
                        rsp_id_r     <= grant_s;
                        last_grant_r <= grant_s;
                        cnt_r        <= CNT_LOAD;
                        alu_valid_r  <= 1'b1;
                        state_r      <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                        rsp_data_r    <= bus.i_alu_result;
                        rsp_illegal_r <= ctrl_illegal(ctrl_r);
                        alu_valid_r   <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        state_r       <= RESP;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    if (rsp_ready_s) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    alu_valid_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule
